// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: holds a 5x5 signed 16-bit kernel in a shadow bank and,
// after a commit, streams it to the filter coefficient port starting at the
// next rising edge of vs_i. All outputs are registered.
//
// Handshake: a beat transfers on a clock edge where valid and ready are both
// high. Once raised, a valid and its payload stay unchanged until that edge,
// except on timeout abort or reset. Address and data channels handshake
// independently; the next index is presented after both have transferred.
module fir_coeff_loader #(
  parameter int          NUM_COEFF      = 25,
  parameter logic [31:0] ADDR_BASE      = 32'd0,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_idx,
  input  logic [15:0] wr_coeff,
  output logic        wr_rej,
  input  logic        commit,
  input  logic        vs_i,
  output logic [31:0] filter_addr,
  output logic        filter_addr_valid,
  input  logic        filter_addr_ready,
  output logic [31:0] filter_data,
  output logic        filter_data_valid,
  input  logic        filter_data_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0]      LAST_IDX = 5'(NUM_COEFF - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_SEND    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          vs_q;
  logic          avld_q, avld_d;
  logic          dvld_q, dvld_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          rej_q, rej_d;
  logic [15:0]   shadow_q [NUM_COEFF];

  // Combinational helpers
  logic          a_left, d_left;
  logic          ld_en, fin;
  logic [4:0]    ld_idx;
  logic [15:0]   ld_coeff;

  // Shadow bank: written only while idle and for in-range indices.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_COEFF; i++) shadow_q[i] <= 16'd0;
    end else if (wr_en && (state_q == ST_IDLE) && (wr_idx <= LAST_IDX)) begin
      shadow_q[wr_idx] <= wr_coeff;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 5'd0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      vs_q    <= 1'b0;
      avld_q  <= 1'b0;
      dvld_q  <= 1'b0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      vs_q    <= vs_i;
      avld_q  <= avld_d;
      dvld_q  <= dvld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rej_q   <= rej_d;
    end
  end

  // Next-state logic: sequencing, per-coefficient handshake tracking, timeout.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    avld_d   = avld_q;
    dvld_d   = dvld_q;
    addr_d   = addr_q;
    data_d   = data_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rej_d    = wr_en & ((state_q != ST_IDLE) | (wr_idx > LAST_IDX));
    ld_en    = 1'b0;
    ld_idx   = 5'd0;
    ld_coeff = 16'd0;
    fin      = 1'b0;
    // A channel is still outstanding if its valid is up and not accepted now.
    a_left   = avld_q & ~filter_addr_ready;
    d_left   = dvld_q & ~filter_data_ready;

    case (state_q)
      ST_IDLE: begin
        if (commit) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (commit) pend_d = 1'b1;
        if (vs_i && !vs_q) begin
          state_d = ST_SEND;
          ld_en   = 1'b1;
          ld_idx  = 5'd0;
        end
      end
      ST_SEND: begin
        if (commit) pend_d = 1'b1;
        avld_d = a_left;
        dvld_d = d_left;
        if (!a_left && !d_left) begin
          if (idx_q == LAST_IDX) begin
            done_d = 1'b1;
            fin    = 1'b1;
          end else begin
            ld_en  = 1'b1;
            ld_idx = idx_q + 5'd1;
          end
        end else if (cnt_q == CNT_LAST) begin
          avld_d = 1'b0;
          dvld_d = 1'b0;
          err_d  = 1'b1;
          fin    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ld_en) begin
      ld_coeff = shadow_q[ld_idx];
      idx_d    = ld_idx;
      cnt_d    = '0;
      avld_d   = 1'b1;
      dvld_d   = 1'b1;
      addr_d   = ADDR_BASE + {27'd0, ld_idx};
      data_d   = {{16{ld_coeff[15]}}, ld_coeff};
    end

    // Leaving SEND: a merged commit request restarts the wait for vs.
    if (fin) begin
      if (pend_q || commit) state_d = ST_WAIT_VS;
      else                  state_d = ST_IDLE;
      pend_d = 1'b0;
    end
  end

  assign busy_d            = (state_d != ST_IDLE);
  assign wr_rej            = rej_q;
  assign filter_addr       = addr_q;
  assign filter_addr_valid = avld_q;
  assign filter_data       = data_q;
  assign filter_data_valid = dvld_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: a kernel model in a shortint array produces the
// expected address/data beats, a monitor pops them on every handshake.
module tb_fir_coeff_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_idx = 5'd0;
  logic [15:0] wr_coeff = 16'd0;
  logic        wr_rej;
  logic        commit = 1'b0;
  logic        vs_i = 1'b0;
  logic [31:0] filter_addr;
  logic        filter_addr_valid;
  logic        filter_addr_ready = 1'b1;
  logic [31:0] filter_data;
  logic        filter_data_valid;
  logic        filter_data_ready = 1'b1;
  logic        busy, done, err;
  logic [1:0]  dbg_state;

  fir_coeff_loader dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_coeff(wr_coeff),
    .wr_rej(wr_rej), .commit(commit), .vs_i(vs_i),
    .filter_addr(filter_addr), .filter_addr_valid(filter_addr_valid),
    .filter_addr_ready(filter_addr_ready),
    .filter_data(filter_data), .filter_data_valid(filter_data_valid),
    .filter_data_ready(filter_data_ready),
    .busy(busy), .done(done), .err(err), .dbg_state_o(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  shortint mdl [25];
  int  rdy_mode = 0;
  bit  quiet = 1'b0;
  int  done_cnt = 0;
  int  err_cnt = 0;
  int  exp_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ready driver: 0 = both ready, 1 = random stalls, 3 = data stalls at index 7
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      1: begin
        filter_addr_ready = 1'($urandom_range(0, 1));
        filter_data_ready = 1'($urandom_range(0, 1));
      end
      3: begin
        filter_addr_ready = 1'b1;
        filter_data_ready = !(filter_data_valid && filter_addr == 32'd7);
      end
      default: begin
        filter_addr_ready = 1'b1;
        filter_data_ready = 1'b1;
      end
    endcase
  end

  // Monitor: beat scoreboard, hold rules, pulse widths
  initial begin
    logic pa_v, pa_hs, pd_v, pd_hs, prev_done, prev_err;
    logic [31:0] pa, pd;
    pa_v = 0; pa_hs = 0; pd_v = 0; pd_hs = 0; prev_done = 0; prev_err = 0;
    pa = 0; pd = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pa_v = 0; pd_v = 0; prev_done = 0; prev_err = 0;
      end else begin
        if (pa_v && !pa_hs && !err) begin
          chk("addr_hold_valid", filter_addr_valid, 1);
          chk("addr_hold_value", filter_addr, pa);
        end
        if (pd_v && !pd_hs && !err) begin
          chk("data_hold_valid", filter_data_valid, 1);
          chk("data_hold_value", filter_data, pd);
        end
        if (quiet) chk("quiet_valids", {filter_addr_valid, filter_data_valid}, 0);
        if (filter_addr_valid && filter_addr_ready) begin
          if (exp_addr_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_addr: got %h expected none", filter_addr);
          end else chk("addr_beat", filter_addr, exp_addr_q.pop_front());
        end
        if (filter_data_valid && filter_data_ready) begin
          if (exp_data_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_data: got %h expected none", filter_data);
          end else chk("data_beat", filter_data, exp_data_q.pop_front());
        end
        if (done) begin done_cnt++; chk("done_width", prev_done, 0); end
        if (err)  begin err_cnt++;  chk("err_width", prev_err, 0); end
        pa_v = filter_addr_valid; pa = filter_addr;
        pa_hs = filter_addr_valid & filter_addr_ready;
        pd_v = filter_data_valid; pd = filter_data;
        pd_hs = filter_data_valid & filter_data_ready;
        prev_done = done; prev_err = err;
      end
    end
  end

  // Driver tasks: all start and end 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int idx, input int val, input bit exp_rej, input bit with_commit);
    logic [31:0] v;
    v = val;
    wr_en = 1'b1; wr_idx = 5'(idx); wr_coeff = v[15:0]; commit = with_commit;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    chk("wr_rej", wr_rej, exp_rej);
    if (!exp_rej) mdl[idx] = shortint'(val);
    if (with_commit) chk("busy_after_commit", busy, 1);
    if (exp_rej) begin
      tick();
      chk("wr_rej_width", wr_rej, 0);
    end
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("busy_after_commit", busy, 1);
  endtask

  task automatic push_kernel();
    for (int i = 0; i < 25; i++) begin
      int v;
      v = mdl[i];
      exp_addr_q.push_back(32'(i));
      exp_data_q.push_back(v);
    end
  endtask

  task automatic vs_pulse();
    vs_i = 1'b1; tick(); tick();
    vs_i = 1'b0; tick();
  endtask

  task automatic wait_done(input int budget);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < budget) begin
      @(negedge clk); n++;
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
    if (seen) exp_done++;
    tick();
  endtask

  initial begin
    int n, nv, nd7;
    bit seen;
    for (int i = 0; i < 25; i++) mdl[i] = 0;

    // Reset state
    repeat (3) tick();
    chk("rst_addr", filter_addr, 0);
    chk("rst_data", filter_data, 0);
    chk("rst_flags", {filter_addr_valid, filter_data_valid, busy, done, err, wr_rej}, 0);
    rst = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Directed ramp kernel, readies high, latency check
    for (int i = 0; i < 24; i++) wr(i, i * 3 - 36, 0, 0);
    wr(24, 24 * 3 - 36, 0, 1);
    push_kernel();
    chk("ramp_idx0_data", exp_data_q[0], 32'hFFFF_FFDC);
    repeat (3) tick();
    vs_i = 1'b1;
    n = 0; nv = 0; seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk); n++;
      if (n == 2) begin #1; vs_i = 1'b0; end
      @(negedge clk);
      if (filter_addr_valid) nv++;
      if (done) begin seen = 1; chk("done_busy_low", busy, 0); end
    end
    chk("vs_to_done_latency", n, 26);
    chk("valid_cycles", nv, 25);
    if (seen) exp_done++;
    tick();

    // Random kernels with random stalls
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 25; i++) wr(i, int'($urandom_range(0, 65535)), 0, 0);
      do_commit();
      push_kernel();
      rdy_mode = 1;
      repeat ($urandom_range(1, 4)) tick();
      vs_pulse();
      wait_done(3000);
      rdy_mode = 0;
      tick();
    end

    // vs already high at commit
    vs_i = 1'b1;
    repeat (3) tick();
    do_commit();
    quiet = 1'b1;
    repeat (20) tick();
    vs_i = 1'b0;
    repeat (3) tick();
    chk("vs_high_still_busy", busy, 1);
    quiet = 1'b0;
    push_kernel();
    vs_i = 1'b1;
    wait_done(200);
    vs_i = 1'b0;
    tick();

    // Timeout at index 7
    rdy_mode = 3;
    do_commit();
    push_kernel();
    vs_pulse();
    n = 0; nd7 = 0; seen = 0;
    while (!seen && n < 3000) begin
      @(negedge clk); n++;
      if (filter_data_valid && filter_addr == 32'd7) nd7++;
      if (err) seen = 1;
    end
    chk("err_seen", seen, 1);
    chk("timeout_length_ok", (nd7 == 1024 || nd7 == 1025), 1);
    tick();
    chk("abort_valids", {filter_addr_valid, filter_data_valid}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr_left", exp_addr_q.size(), 17);
    chk("abort_data_left", exp_data_q.size(), 18);
    chk("abort_no_done", done_cnt, exp_done);
    exp_addr_q.delete();
    exp_data_q.delete();
    rdy_mode = 0;
    tick();

    // Rejected writes, merged commits
    wr(25, 16'h1234, 1, 0);
    do_commit();
    wr(3, 16'h7777, 1, 0);
    push_kernel();
    vs_pulse();
    do_commit();
    do_commit();
    push_kernel();
    wait_done(200);
    chk("busy_pending", busy, 1);
    vs_pulse();
    wait_done(200);
    repeat (2) tick();
    chk("idle_after_pending", busy, 0);
    quiet = 1'b1;
    vs_pulse();
    repeat (30) tick();
    quiet = 1'b0;
    chk("no_extra_load", exp_addr_q.size(), 0);

    // Reset in the middle of a load
    do_commit();
    push_kernel();
    vs_pulse();
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk); n++;
      if (filter_addr_valid && filter_addr == 32'd12) seen = 1;
    end
    chk("reached_idx12", seen, 1);
    #2; rst = 1'b0;
    #1;
    chk("midrst_addr", filter_addr, 0);
    chk("midrst_data", filter_data, 0);
    chk("midrst_flags", {filter_addr_valid, filter_data_valid, busy, done, err, wr_rej}, 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < 25; i++) mdl[i] = 0;
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_idle", busy, 0);
    do_commit();
    push_kernel();
    vs_pulse();
    wait_done(200);
    repeat (3) tick();

    // Totals
    chk("done_total", done_cnt, exp_done);
    chk("err_total", err_cnt, 1);
    chk("addr_q_empty", exp_addr_q.size(), 0);
    chk("data_q_empty", exp_data_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
